// File: rtl/hog_cell_histogram.sv
// hog_cell_histogram
//   Accumulates one HOG cell. Each sample is a gradient magnitude plus an
//   integer-degree angle. The angle selects one of NBINS unsigned-angle bins,
//   each BIN_DEG wide. After CELL_PIX samples the finished histogram moves
//   to a one-deep output buffer with a valid/ready handshake, and the next
//   cell starts from zero.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   clear        synchronous flush of partial cell and output buffer
//   in_valid     sample qualifier; accepted when in_valid && in_ready
//   in_ready     sample acceptance (low only when a cell end would be blocked)
//   magnitude    unsigned sample magnitude, MAG_W bits
//   angle        unsigned sample angle in degrees, ANG_W bits
//   hist_valid   a completed histogram is held
//   hist_ready   consumer acceptance of the held histogram
//   hist         held histogram, bin k at [k*ACC_W +: ACC_W]
//   hist_sat     some bin of the held histogram saturated
//   ang_err      held cell contained an out-of-range angle
module hog_cell_histogram #(
  parameter int MAG_W    = 14,
  parameter int ANG_W    = 9,
  parameter int ACC_W    = 18,
  parameter int NBINS    = 9,
  parameter int BIN_DEG  = 20,
  parameter int CELL_PIX = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [MAG_W-1:0]         magnitude,
  input  logic [ANG_W-1:0]         angle,
  output logic                     hist_valid,
  input  logic                     hist_ready,
  output logic [NBINS*ACC_W-1:0]   hist,
  output logic                     hist_sat,
  output logic                     ang_err
);

  localparam int CNT_W = (CELL_PIX > 1) ? $clog2(CELL_PIX) : 1;
  // One spare bit over the wider operand so the carry out is visible.
  localparam int SUM_W = ((ACC_W > MAG_W) ? ACC_W : MAG_W) + 1;
  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(CELL_PIX - 1);
  localparam logic [SUM_W-1:0] ACC_MAX  = {{(SUM_W-ACC_W){1'b0}}, {ACC_W{1'b1}}};

  typedef enum logic {S_EMPTY, S_FULL} state_t;

  state_t                         r_state;
  state_t                         w_state_next;
  logic                           r_alive;
  logic [CNT_W-1:0]               r_cnt;
  logic [NBINS-1:0][ACC_W-1:0]    r_acc;
  logic                           r_sat;
  logic                           r_err;
  logic [NBINS*ACC_W-1:0]         r_hist;
  logic                           r_hist_sat;
  logic                           r_ang_err;

  logic [31:0]                    w_ang_ext;
  logic                           w_ang_zero;
  logic                           w_oor;
  logic [NBINS-1:0]               w_hit;
  logic [NBINS-1:0]               w_ovf;
  logic [NBINS-1:0][ACC_W-1:0]    w_acc_next;
  logic                           w_accept;
  logic                           w_cell_end;
  logic                           w_cell_sat;
  logic                           w_cell_err;

  // Angle widened to 32 bits so bin limits above 2^ANG_W compare correctly;
  // in that case w_oor is simply never true.
  assign w_ang_ext  = {{(32-ANG_W){1'b0}}, angle};
  assign w_ang_zero = (angle == '0);
  assign w_oor      = (w_ang_ext > 32'(NBINS*BIN_DEG));

  // A clear in the same cycle drops the sample.
  assign w_accept   = in_valid && in_ready && !clear;
  assign w_cell_end = w_accept && (r_cnt == LAST_PIX);

  // Bin k covers (k*BIN_DEG, (k+1)*BIN_DEG]; 0 degrees folds onto 180,
  // so it goes to the last bin. Pure range compares, no divider.
  generate
    for (genvar gi = 0; gi < NBINS; gi++) begin : g_bin
      logic             w_in_range;
      logic [SUM_W-1:0] w_sum;

      assign w_in_range = (w_ang_ext > 32'(gi*BIN_DEG)) &&
                          (w_ang_ext <= 32'((gi+1)*BIN_DEG));
      if (gi == NBINS-1) begin : g_last
        assign w_hit[gi] = w_in_range || w_ang_zero;
      end else begin : g_mid
        assign w_hit[gi] = w_in_range;
      end

      assign w_sum = SUM_W'(r_acc[gi]) +
                     ((w_accept && w_hit[gi]) ? SUM_W'(magnitude) : '0);
      assign w_ovf[gi]      = (w_sum > ACC_MAX);
      assign w_acc_next[gi] = w_ovf[gi] ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
    end
  endgenerate

  // Flags include the sample being accepted so the cell-end snapshot is complete.
  assign w_cell_sat = r_sat | (|w_ovf);
  assign w_cell_err = r_err | (w_accept && w_oor);

  // Cell accumulation state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_acc <= '0;
      r_sat <= 1'b0;
      r_err <= 1'b0;
    end else if (clear || w_cell_end) begin
      r_cnt <= '0;
      r_acc <= '0;
      r_sat <= 1'b0;
      r_err <= 1'b0;
    end else if (w_accept) begin
      r_cnt <= r_cnt + CNT_W'(1);
      r_acc <= w_acc_next;
      r_sat <= w_cell_sat;
      r_err <= w_cell_err;
    end
  end

  // Output buffer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hist     <= '0;
      r_hist_sat <= 1'b0;
      r_ang_err  <= 1'b0;
    end else if (clear) begin
      r_hist     <= '0;
      r_hist_sat <= 1'b0;
      r_ang_err  <= 1'b0;
    end else if (w_cell_end) begin
      r_hist     <= w_acc_next;
      r_hist_sat <= w_cell_sat;
      r_ang_err  <= w_cell_err;
    end
  end

  // Output-buffer FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_EMPTY: begin
        if (w_cell_end) w_state_next = S_FULL;
      end
      S_FULL: begin
        // A cell end while FULL only gets through when hist_ready is high,
        // so the old buffer is consumed in the same cycle it is reloaded.
        if (w_cell_end)      w_state_next = S_FULL;
        else if (hist_ready) w_state_next = S_EMPTY;
      end
      default: w_state_next = S_EMPTY;
    endcase
    if (clear) w_state_next = S_EMPTY;
  end

  // Keeps in_ready low while reset is asserted and for the first edge after it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_alive <= 1'b0;
    else        r_alive <= 1'b1;
  end

  // Stall only when this sample would end a cell while the buffer is still owned.
  assign in_ready   = r_alive &&
                      !((r_cnt == LAST_PIX) && (r_state == S_FULL) && !hist_ready);
  assign hist_valid = (r_state == S_FULL);
  assign hist       = r_hist;
  assign hist_sat   = r_hist_sat;
  assign ang_err    = r_ang_err;

endmodule

// File: tb/tb_hog_cell_histogram.sv
`timescale 1ns/1ps
module tb_hog_cell_histogram;

  localparam int NB = 9;
  localparam int AA = 18;
  localparam int AB = 15;
  localparam int MW = 14;
  localparam int AW = 9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          clear;
  logic          in_valid;
  logic          hist_ready;
  logic [MW-1:0] magnitude;
  logic [AW-1:0] angle;

  logic             in_ready, hist_valid, hist_sat, ang_err;
  logic [NB*AA-1:0] hist;
  logic             in_ready_b, hist_valid_b, hist_sat_b, ang_err_b;
  logic [NB*AB-1:0] hist_b;

  hog_cell_histogram #(.MAG_W(MW), .ANG_W(AW), .ACC_W(AA), .NBINS(NB),
                       .BIN_DEG(20), .CELL_PIX(4)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
    .in_ready(in_ready), .magnitude(magnitude), .angle(angle),
    .hist_valid(hist_valid), .hist_ready(hist_ready), .hist(hist),
    .hist_sat(hist_sat), .ang_err(ang_err));

  // Same stimulus, narrower accumulators to exercise saturation.
  hog_cell_histogram #(.MAG_W(MW), .ANG_W(AW), .ACC_W(AB), .NBINS(NB),
                       .BIN_DEG(20), .CELL_PIX(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
    .in_ready(in_ready_b), .magnitude(magnitude), .angle(angle),
    .hist_valid(hist_valid_b), .hist_ready(hist_ready), .hist(hist_b),
    .hist_sat(hist_sat_b), .ang_err(ang_err_b));

  typedef struct packed {
    logic [3:0][AW-1:0]    ang;
    logic [3:0][MW-1:0]    mag;
    logic [NB-1:0][AA-1:0] exp_bin;
    logic                  exp_sat;
    logic                  exp_err;
    logic [AB-1:0]         exp_b4;
    logic                  exp_bsat;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic vec_t mk(input int a0, a1, a2, a3, m0, m1, m2, m3,
                              input int e0, e1, e2, e3, e4, e5, e6, e7, e8,
                              input int s, er, b4, bs);
    vec_t v;
    v.ang[0] = AW'(a0); v.ang[1] = AW'(a1); v.ang[2] = AW'(a2); v.ang[3] = AW'(a3);
    v.mag[0] = MW'(m0); v.mag[1] = MW'(m1); v.mag[2] = MW'(m2); v.mag[3] = MW'(m3);
    v.exp_bin[0] = AA'(e0); v.exp_bin[1] = AA'(e1); v.exp_bin[2] = AA'(e2);
    v.exp_bin[3] = AA'(e3); v.exp_bin[4] = AA'(e4); v.exp_bin[5] = AA'(e5);
    v.exp_bin[6] = AA'(e6); v.exp_bin[7] = AA'(e7); v.exp_bin[8] = AA'(e8);
    v.exp_sat  = (s != 0);
    v.exp_err  = (er != 0);
    v.exp_b4   = AB'(b4);
    v.exp_bsat = (bs != 0);
    return v;
  endfunction

  task automatic send(input int a, input int m);
    @(negedge clk);
    in_valid  = 1'b1;
    angle     = AW'(a);
    magnitude = MW'(m);
  endtask

  // Feeds one 4-sample cell with hist_ready high and checks the snapshot.
  task automatic run_cell(input vec_t v, input string tag);
    hist_ready = 1'b1;
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      if (s == 3) chk({tag, "_valid_early"}, 64'(hist_valid), 64'd0);
      in_valid  = 1'b1;
      angle     = v.ang[s];
      magnitude = v.mag[s];
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, "_valid"}, 64'(hist_valid), 64'd1);
    for (int k = 0; k < NB; k++)
      chk($sformatf("%s_bin%0d", tag, k), 64'(hist[k*AA +: AA]), 64'(v.exp_bin[k]));
    chk({tag, "_sat"}, 64'(hist_sat), 64'(v.exp_sat));
    chk({tag, "_err"}, 64'(ang_err), 64'(v.exp_err));
    chk({tag, "_b_bin4"}, 64'(hist_b[4*AB +: AB]), 64'(v.exp_b4));
    chk({tag, "_b_sat"}, 64'(hist_sat_b), 64'(v.exp_bsat));
  endtask

  vec_t vecs[5];

  initial begin
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; hist_ready = 1'b1;
    magnitude = '0; angle = '0;

    //            angles            magnitudes              bins 0..8                          sat err b4 bsat
    vecs[0] = mk(10, 30, 180, 0,   5, 5, 5, 5,             5, 5, 0, 0, 0, 0, 0, 0, 10,        0, 0, 0, 0);
    vecs[1] = mk(20, 21, 1, 40,    1, 2, 3, 4,             4, 6, 0, 0, 0, 0, 0, 0, 0,         0, 0, 0, 0);
    vecs[2] = mk(90, 90, 90, 90,   16383, 16383, 16383, 16383,
                                                            0, 0, 0, 0, 65532, 0, 0, 0, 0,     0, 0, 32767, 1);
    vecs[3] = mk(200, 5, 181, 100, 7, 9, 11, 13,           9, 0, 0, 0, 13, 0, 0, 0, 0,        0, 1, 13, 0);
    vecs[4] = mk(160, 161, 179, 60, 1, 2, 3, 4,            0, 0, 4, 0, 0, 0, 0, 1, 5,         0, 0, 0, 0);

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_hist_valid", 64'(hist_valid), 64'd0);
    chk("rst_hist_zero", 64'(hist == '0), 64'd1);
    chk("rst_hist_sat", 64'(hist_sat), 64'd0);
    chk("rst_ang_err", 64'(ang_err), 64'd0);
    rst_n = 1'b1;
    #1 chk("in_ready_before_edge", 64'(in_ready), 64'd0);
    @(negedge clk);
    chk("in_ready_after_edge", 64'(in_ready), 64'd1);

    // Table-driven cells
    for (int i = 0; i < 5; i++) run_cell(vecs[i], $sformatf("vec%0d", i));

    // Backpressure: 8 samples stream with hist_ready low
    @(negedge clk);
    hist_ready = 1'b0;
    for (int k = 0; k < 8; k++) send((k < 4) ? 10 : 30, (k < 4) ? 1 : 2);
    #1 chk("bp_in_ready_low", 64'(in_ready), 64'd0);
    for (int w = 0; w < 3; w++) begin
      @(negedge clk);
      chk("bp_hold_valid", 64'(hist_valid), 64'd1);
      chk("bp_hold_bin0", 64'(hist[0 +: AA]), 64'd4);
      chk("bp_hold_bin1", 64'(hist[AA +: AA]), 64'd0);
    end
    hist_ready = 1'b1;
    #1 chk("bp_in_ready_release", 64'(in_ready), 64'd1);
    @(negedge clk);
    hist_ready = 1'b0;
    in_valid   = 1'b0;
    chk("bp_second_valid", 64'(hist_valid), 64'd1);
    chk("bp_second_bin0", 64'(hist[0 +: AA]), 64'd0);
    chk("bp_second_bin1", 64'(hist[AA +: AA]), 64'd8);
    @(negedge clk);
    hist_ready = 1'b1;
    @(negedge clk);
    chk("bp_drained", 64'(hist_valid), 64'd0);

    // Reset while a histogram is held and a cell is half done
    hist_ready = 1'b0;
    for (int k = 0; k < 4; k++) send(10, 1);
    send(10, 100);
    send(10, 100);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("midrst_in_ready", 64'(in_ready), 64'd0);
    chk("midrst_hist_valid", 64'(hist_valid), 64'd0);
    chk("midrst_hist_zero", 64'(hist == '0), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    run_cell(mk(50, 50, 50, 50, 1, 1, 1, 1, 0, 0, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "after_rst");

    // Clear with a coincident sample, while a histogram is held
    hist_ready = 1'b0;
    for (int k = 0; k < 4; k++) send(10, 1);
    send(10, 3);
    send(10, 3);
    @(negedge clk);
    clear = 1'b1; in_valid = 1'b1; angle = AW'(30); magnitude = MW'(50);
    @(negedge clk);
    clear = 1'b0; in_valid = 1'b0;
    chk("clr_hist_valid", 64'(hist_valid), 64'd0);
    chk("clr_hist_zero", 64'(hist == '0), 64'd1);
    chk("clr_in_ready", 64'(in_ready), 64'd1);
    run_cell(mk(150, 150, 150, 150, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 4, 0, 0, 0, 0, 0), "after_clr");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hog_cell_histogram.md
HOG_CELL_HISTOGRAM -- requirements
Module: hog_cell_histogram

Interface
REQ-001 SHALL provide parameter MAG_W, default 14, the unsigned magnitude width.
REQ-002 SHALL provide parameter ANG_W, default 9, the unsigned integer-degree angle width.
REQ-003 SHALL provide parameter ACC_W, default 18, the width of each bin accumulator.
REQ-004 SHALL provide parameter NBINS, default 9, the number of histogram bins.
REQ-005 SHALL provide parameter BIN_DEG, default 20, the width of each bin in degrees.
REQ-006 SHALL provide parameter CELL_PIX, default 64, the number of samples per cell.
REQ-007 SHALL provide port clk, input, 1 bit, the single clock; all logic is rising-edge.
REQ-008 SHALL provide port rst_n, input, 1 bit, an asynchronous active-low reset.
REQ-009 SHALL provide port clear, input, 1 bit, a synchronous flush of all cell state.
REQ-010 SHALL provide port in_valid, input, 1 bit, qualifying a sample.
REQ-011 SHALL provide port in_ready, output, 1 bit; a sample is accepted when in_valid and in_ready are both 1.
REQ-012 SHALL provide port magnitude, input, MAG_W bits, the sample magnitude.
REQ-013 SHALL provide port angle, input, ANG_W bits, the sample angle in degrees.
REQ-014 SHALL provide port hist_valid, output, 1 bit, marking a completed histogram as held.
REQ-015 SHALL provide port hist_ready, input, 1 bit, the consumer acceptance.
REQ-016 SHALL provide port hist, output, NBINS*ACC_W bits, with bin k at [k*ACC_W +: ACC_W].
REQ-017 SHALL provide port hist_sat, output, 1 bit, set if any bin of the held histogram saturated.
REQ-018 SHALL provide port ang_err, output, 1 bit, set if the held cell contained an out-of-range angle.

Function
REQ-019 SHALL map each accepted angle a to a bin as follows: a in 1..NBINS*BIN_DEG → bin (a-1)/BIN_DEG; a==0 → bin NBINS-1 (0° ≡ 180°); a>NBINS*BIN_DEG → no bin.
REQ-020 SHALL compute the bin mapping with a comparator chain and no divider.
REQ-021 SHALL add the zero-extended magnitude to the selected accumulator in the accept cycle.
REQ-022 SHALL saturate a bin at 2^ACC_W-1 on overflow and set the cell's sat flag.
REQ-023 SHALL count an out-of-range sample toward CELL_PIX, add nothing, and set the cell's err flag.
REQ-024 SHALL use a pixel counter over 0..CELL_PIX-1; accepting sample CELL_PIX-1 is the cell end.
REQ-025 SHALL, at cell end, load hist, hist_sat and hist_ert with the final sums including the last sample, and assert hist_valid the next cycle (latency 1).
REQ-026 SHALL, at cell end, zero the accumulators, counter and cell flags so the next sample starts a new cell.
REQ-027 SHALL implement an output-buffer FSM: EMPTY→FULL on cell end; FULL→EMPTY on hist_valid&&hist_ready without a coincident cell end; FULL stays FULL on handshake plus cell end, with the buffer reloaded.
REQ-028 SHALL hold hist, hist_sat and ang_err stable while hist_valid=1 and hist_ready=0.
REQ-029 SHALL keep in_ready=1 except when the counter equals CELL_PIX-1, the FSM is FULL and hist_ready=0; no completed histogram is ever overwritten or lost.
REQ-030 SHALL let clear zero the accumulators, counter, cell flags and output buffer (FSM→EMPTY, hist_valid=0) next cycle.
REQ-031 SHALL give clear priority over a coincident sample, which is dropped.
REQ-032 SHALL treat NBINS*BIN_DEG ≥ 2^ANG_W as legal (ang_err never set in that case).

Reset
REQ-033 SHALL, while rst_n=0, immediately force in_ready=0, hist_valid=0, hist=0, hist_sat=0, ang_err=0, all accumulators=0, counter=0 and FSM=EMPTY.
REQ-034 SHALL assert in_ready on the first rising clk edge after rst_n deasserts.
REQ-035 SHALL, on reset mid-cell or mid-handshake, discard the partial cell and the held histogram.

Verification (CELL_PIX=4, defaults otherwise)
REQ-036 SHALL be checked with: angles 10,30,180,0 and magnitude 5 each, hist_ready=1 → hist_valid 1 cycle after the 4th sample; bin0=5, bin1=5, bin8=10, others 0; flags 0.
REQ-037 SHALL be checked with: angles 20,21,1,40 and magnitudes 1,2,3,4 → bin0=4, bin1=6.
REQ-038 SHALL be checked with: 4 samples of angle 90 and magnitude 16383 → bin4=65532; then ACC_W=15 rerun → bin4=32767 and hist_sat=1.
REQ-039 SHALL be checked with: hist_ready=0 while 8 samples stream → in_ready drops on the 8th sample; first hist stable; after hist_ready pulse the second hist appears with no loss.
REQ-040 SHALL be checked with: angle 200 in a cell → ang_err=1 and counted but not accumulated; angle 181 → same.
REQ-041 SHALL be checked with: rst_n pulsed low after 2 samples, and separately clear with in_valid → next cell starts from zero with the dropped sample absent.
